kvs_req_arbiter: RTL

Round-robin arbiter that shares the single db_top lookup port (key/flag/valid/ready in, valid/flag out) among NREQ requesters, e.g. per-Ethernet-port KVS query engines. It sits in the db_clk domain between the eth_top request sources and db_top. db_top answers strictly in request order with no backpressure, so the block records the grant order in a tag FIFO and steers each response back to its originator. It also caps the number of outstanding lookups.

---
 rtl/kvs_arb_pkg.sv | 23 ++
 rtl/kvs_tag_fifo.sv | 58 +++++
 rtl/kvs_req_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kvs_arb_pkg.sv
// Shared definitions for the KVS request arbiter.
//   FLAG_W_DEF : default flag width on db_top request/response
//   FLAG_*     : flag encodings shared with db_top
//   clog2()    : constant ceil(log2) helper used for tag/pointer widths
package kvs_arb_pkg;

  localparam int unsigned FLAG_W_DEF = 4;

  localparam logic [FLAG_W_DEF-1:0] FLAG_GET = 4'h1;
  localparam logic [FLAG_W_DEF-1:0] FLAG_SET = 4'h2;
  localparam logic [FLAG_W_DEF-1:0] FLAG_HIT = 4'h4;

  // ceil(log2(v)) for elaboration-time widths; returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kvs_tag_fifo.sv
// Tag FIFO recording which requester owns each in-flight lookup.
// Ports: clk, rst (async active-high), push/din, pop/dout (head, show-ahead),
//        full, empty, count (occupancy 0..DEPTH).
// A push while full is accepted only if a pop happens in the same cycle.
module kvs_tag_fifo
  import kvs_arb_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [W-1:0]                din,
  input  logic                        pop,
  output logic [W-1:0]                dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage and pointers; pointers wrap naturally at DEPTH (power of 2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kvs_req_arbiter.sv
// Round-robin arbiter sharing the db_top lookup port among NREQ requesters.
// Responses from db_top come back in request order, so grant order is kept
// in a tag FIFO and each response is steered back to its originator.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_key/req_flag/req_valid    per-requester request lanes
//   req_ready                     one-hot accept strobe (combinational)
//   db_key/db_flag/db_valid       registered request to db_top, db_ready in
//   db_out_valid/db_out_flag      db_top response (no backpressure)
//   rsp_valid/rsp_flag            per-requester response pulse and flag
//   outstanding                   lookups in flight
//   err_orphan                    sticky: response with no tag outstanding
// Optional: define KVS_ARB_STATS_EN to add grant_cnt and stall_cnt counters.
module kvs_req_arbiter
  import kvs_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned KEY_SIZE  = 96,
  parameter int unsigned FLAG_W    = FLAG_W_DEF,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ*KEY_SIZE-1:0]        req_key,
  input  logic [NREQ*FLAG_W-1:0]          req_flag,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  output logic [KEY_SIZE-1:0]             db_key,
  output logic [FLAG_W-1:0]               db_flag,
  output logic                            db_valid,
  input  logic                            db_ready,
  input  logic                            db_out_valid,
  input  logic [FLAG_W-1:0]               db_out_flag,
  output logic [NREQ-1:0]                 rsp_valid,
  output logic [NREQ*FLAG_W-1:0]          rsp_flag,
  output logic [$clog2(MAX_OUTST+1)-1:0]  outstanding,
`ifdef KVS_ARB_STATS_EN
  output logic [NREQ*32-1:0]              grant_cnt,
  output logic [31:0]                     stall_cnt,
`endif
  output logic                            err_orphan
);

  localparam int unsigned TAG_W = clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST+1);

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant_idx_c;
  logic [TAG_W-1:0] rr_next_c;
  logic             grant_any_c;
  logic             can_accept_c;
  logic             accept_c;
  logic             pop_c;
  logic             fifo_empty;
  logic             fifo_full;
  logic [TAG_W-1:0] head_tag;

  assign can_accept_c = (!db_valid || db_ready) && (outstanding < CNT_W'(MAX_OUTST));
  assign accept_c     = can_accept_c && grant_any_c;
  assign pop_c        = db_out_valid && !fifo_empty;

  // First valid requester at or after rr_ptr, modulo NREQ
  always_comb begin
    int unsigned      idx;
    logic [TAG_W-1:0] idx_t;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    req_ready   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_t = TAG_W'(idx);
      if (!grant_any_c && req_valid[idx_t]) begin
        grant_any_c = 1'b1;
        grant_idx_c = idx_t;
      end
    end
    req_ready[grant_idx_c] = accept_c;
  end

  assign rr_next_c = (32'(grant_idx_c) == NREQ - 1) ? '0 : grant_idx_c + TAG_W'(1);

  // Request output register, round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_valid <= 1'b0;
      db_key   <= '0;
      db_flag  <= '0;
      rr_ptr   <= '0;
    end else if (accept_c) begin
      db_valid <= 1'b1;
      db_key   <= req_key[32'(grant_idx_c)*KEY_SIZE +: KEY_SIZE];
      db_flag  <= req_flag[32'(grant_idx_c)*FLAG_W +: FLAG_W];
      rr_ptr   <= rr_next_c;
    end else if (db_ready) begin
      db_valid <= 1'b0;
    end
  end

  // Response steering; rsp_flag lanes hold their last value between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_flag   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (pop_c) begin
        rsp_valid[head_tag]                        <= 1'b1;
        rsp_flag[32'(head_tag)*FLAG_W +: FLAG_W]   <= db_out_flag;
      end
      if (db_out_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  kvs_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_c),
    .din   (grant_idx_c),
    .pop   (pop_c),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

`ifdef KVS_ARB_STATS_EN
  // Saturating per-requester accept counters and arbitration stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_ready[i] && (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
      if ((|req_valid) && !can_accept_c && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
